apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decoder.sv | 22 ++
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 tb/tb_apb_master_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge: FSM state encoding,
// slave count, decode base page and access timeout.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam int          NUM_SLV_DEF = 4;
  localparam int          TIMEOUT_DEF = 16;
  localparam logic [19:0] BASE_PAGE   = 20'h10000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: slave i owns the 4 KiB page BASE_PAGE + i.
// Produces a one-hot select vector and a hit flag.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLV = NUM_SLV_DEF
) (
  input  logic [31:0]        addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = (addr[31:12] == (BASE_PAGE + 20'(i)));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge: one transfer at a time through IDLE/SETUP/ACCESS/DONE
// with address decode, PREADY timeout and a one-cycle ready/error completion pulse.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLV = NUM_SLV_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     transfer,
  input  logic [31:0]              addr,
  input  logic                     write,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     error,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic                     PENABLE,
  output logic [NUM_SLV-1:0]       PSEL,
  input  logic [NUM_SLV-1:0][31:0] PRDATA,
  input  logic [NUM_SLV-1:0]       PREADY,
  output apb_state_e               dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e        state;
  logic [CW-1:0]     cnt;
  logic [NUM_SLV-1:0] dec_sel;
  logic              dec_hit;
  logic              sel_ready;
  logic [31:0]       sel_rdata;

  apb_addr_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
    .addr (addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Only the slave we are currently selecting may complete or return data.
  always_comb begin
    sel_ready = |(PREADY & PSEL);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          rdata <= '0;
          if (transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            if (dec_hit) begin
              PSEL  <= dec_sel;
              state <= ST_SETUP;
            end else begin
              ready <= 1'b1;
              error <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            rdata   <= PWRITE ? 32'h0 : sel_rdata;
            ready   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            cnt     <= '0;
            state   <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Slave never answered: abandon the access and report an error.
            rdata   <= '0;
            ready   <= 1'b1;
            error   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            cnt     <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rdata <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed table-driven bench for apb_master_bridge with a simple APB slave
// model (programmable wait states, off-target PREADY noise) and corner sequences.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int NS = 4;

  logic                PCLK = 1'b0;
  logic                PRESET = 1'b1;
  logic                transfer = 1'b0;
  logic [31:0]         addr = '0;
  logic                write = 1'b0;
  logic [31:0]         wdata = '0;
  logic [31:0]         rdata;
  logic                ready;
  logic                error;
  logic [31:0]         PADDR;
  logic                PWRITE;
  logic [31:0]         PWDATA;
  logic                PENABLE;
  logic [NS-1:0]       PSEL;
  logic [NS-1:0][31:0] PRDATA;
  logic [NS-1:0]       PREADY;
  apb_state_e          dbg_state;

  apb_master_bridge #(.NUM_SLV(NS), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .addr(addr),
    .write(write), .wdata(wdata), .rdata(rdata), .ready(ready), .error(error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: target slave answers after slv_waits ACCESS cycles,
  // the others drive constant noise on PREADY and a distinct PRDATA.
  int          slv_tgt = 0;
  int          slv_waits = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_noise = 1'b0;
  int          wcnt = 0;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (i == slv_tgt) begin
        PRDATA[i] = slv_rdata;
        PREADY[i] = PSEL[i] && PENABLE && (wcnt >= slv_waits);
      end else begin
        PRDATA[i] = 32'hBAD0_0000 | 32'(i);
        PREADY[i] = slv_noise;
      end
    end
  end

  always @(posedge PCLK) begin
    if (PSEL[slv_tgt] && PENABLE && !PREADY[slv_tgt]) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          tgt;
    int          waits;
    logic [31:0] srdata;
    logic        noise;
    logic [3:0]  exp_psel;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int k;
    bit seen;
    slv_tgt   = v.tgt;
    slv_waits = v.waits;
    slv_rdata = v.srdata;
    slv_noise = v.noise;
    @(negedge PCLK);
    transfer = 1'b1;
    addr     = v.addr;
    write    = v.write;
    wdata    = v.wdata;
    @(negedge PCLK);
    transfer = 1'b0;
    k = 1;
    if (v.exp_psel != 4'b0) begin
      check("setup_psel", 32'(PSEL), 32'(v.exp_psel));
      check("setup_penable", 32'(PENABLE), 32'h0);
    end
    seen = 0;
    while (k < 40 && !seen) begin
      if (ready) begin
        seen = 1;
      end else begin
        if (k == 2) begin
          check("access_psel", 32'(PSEL), 32'(v.exp_psel));
          check("access_penable", 32'(PENABLE), 32'h1);
          check("access_paddr", PADDR, v.addr);
          check("access_pwrite", 32'(PWRITE), 32'(v.write));
          if (v.write) check("access_pwdata", PWDATA, v.wdata);
        end
        @(negedge PCLK);
        k++;
      end
    end
    check("latency", 32'(k), 32'(v.exp_lat));
    check("done_error", 32'(error), 32'(v.exp_err));
    check("done_rdata", rdata, v.exp_rdata);
    check("done_psel", 32'(PSEL), 32'h0);
    check("done_penable", 32'(PENABLE), 32'h0);
    if (v.write && v.exp_psel != 4'b0) check("done_pwdata", PWDATA, v.wdata);
    @(negedge PCLK);
    check("ready_single_pulse", 32'(ready), 32'h0);
  endtask

  initial begin
    vec_t v;
    //          addr          wr  wdata         tgt w    srdata        noise psel     lat err rdata
    vecs.push_back('{32'h1000_1004, 1'b1, 32'h0000_00A5, 1, 0,   32'h0,         1'b0, 4'b0010, 3,  1'b0, 32'h0});
    vecs.push_back('{32'h1000_2008, 1'b0, 32'h0,         2, 1,   32'h0000_0003, 1'b0, 4'b0100, 4,  1'b0, 32'h3});
    vecs.push_back('{32'h2000_0000, 1'b0, 32'h0,         0, 0,   32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0});
    vecs.push_back('{32'h1000_3000, 1'b0, 32'h0,         3, 255, 32'h5555_5555, 1'b1, 4'b1000, 18, 1'b1, 32'h0});
    vecs.push_back('{32'h1000_0FFC, 1'b0, 32'h0,         0, 2,   32'hDEAD_BEEF, 1'b1, 4'b0001, 5,  1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h1000_4000, 1'b1, 32'h1111_1111, 0, 0,   32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0});
    vecs.push_back('{32'h1000_1010, 1'b0, 32'h0,         1, 0,   32'h1234_5678, 1'b1, 4'b0010, 3,  1'b0, 32'h1234_5678});
    vecs.push_back('{32'h1000_3FFC, 1'b1, 32'hFFFF_FFFF, 3, 3,   32'h7777_7777, 1'b0, 4'b1000, 6,  1'b0, 32'h0});
    vecs.push_back('{32'h0000_1000, 1'b0, 32'h0,         0, 0,   32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0});

    // Reset values
    #12;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge PCLK);
    PRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

    // Reset in the middle of an ACCESS phase to a silent slave
    slv_tgt = 3; slv_waits = 255; slv_noise = 1'b0;
    @(negedge PCLK);
    transfer = 1'b1; addr = 32'h1000_3000; write = 1'b0;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_penable", 32'(PENABLE), 32'h1);
    #1 PRESET = 1'b1;
    #1;
    check("async_rst_psel", 32'(PSEL), 32'h0);
    check("async_rst_penable", 32'(PENABLE), 32'h0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge PCLK);
      check("no_ready_after_reset", 32'(ready), 32'h0);
    end
    v = vecs[0];
    run_txn(v);

    // transfer held high: a new zero-wait write starts every 4 cycles
    slv_tgt = 1; slv_waits = 0; slv_noise = 1'b0;
    @(negedge PCLK);
    transfer = 1'b1; addr = 32'h1000_1004; write = 1'b1; wdata = 32'h0000_00A5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      check("b2b_ready", 32'(ready), (k % 4 == 3) ? 32'h1 : 32'h0);
      if (k % 4 == 1) check("b2b_setup_psel", 32'(PSEL), 32'h2);
    end
    transfer = 1'b0;
    repeat (4) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
